// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX operand-select stage and the iterative
// multiply/divide unit.
interface mdu_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  kill;
  logic                  busy;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, op, data1, data2, kill,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, op, data1, data2, kill,
    output busy, result_valid, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with signs and special cases fixed up at the end.
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input logic        clk,
  input logic        rst,
  mdu_iter_if.slave  bus
);
  localparam int N = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N - 1);
  localparam logic [N-1:0]         MOST_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0]           op_q;
  logic                 negA_q;
  logic                 negB_q;
  logic                 divZero_q;
  logic                 ovf_q;
  logic [N-1:0]         opA_q;
  logic [2*N-1:0]       acc_q;
  logic [N-1:0]         dvd_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [N-1:0]         result_q;

  logic                 capSignA;
  logic                 capSignB;
  logic                 capNegA;
  logic                 capNegB;
  logic [N-1:0]         capAbsA;
  logic [N-1:0]         capAbsB;

  always_comb begin
    capSignA = 1'b0;
    capSignB = 1'b0;
    case (bus.op)
      3'b001, 3'b100, 3'b110: begin
        capSignA = 1'b1;
        capSignB = 1'b1;
      end
      3'b010:  capSignA = 1'b1;
      default: ;
    endcase
    capNegA = capSignA & bus.data1[N-1];
    capNegB = capSignB & bus.data2[N-1];
    capAbsA = capNegA ? -bus.data1 : bus.data1;
    capAbsB = capNegB ? -bus.data2 : bus.data2;
  end

  // acc_q holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [N:0]     mulSum;
  logic [2*N-1:0] mulNext;
  logic [N:0]     divShift;
  logic [N:0]     divDiff;
  logic [2*N-1:0] divNext;
  logic [2*N-1:0] stepAcc;

  always_comb begin
    mulSum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opA_q} : '0);
    mulNext  = {mulSum, acc_q[N-1:1]};
    divShift = {acc_q[2*N-1:N], acc_q[N-1]};
    divDiff  = divShift - {1'b0, opA_q};
    if (divDiff[N]) begin
      divNext = {divShift[N-1:0], acc_q[N-2:0], 1'b0};
    end else begin
      divNext = {divDiff[N-1:0], acc_q[N-2:0], 1'b1};
    end
    stepAcc = op_q[2] ? divNext : mulNext;
  end

  logic [2*N-1:0] prodFinal;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;
  logic [N-1:0]   finalRes;

  always_comb begin
    prodFinal = (negA_q ^ negB_q) ? -stepAcc : stepAcc;
    quo       = (negA_q ^ negB_q) ? -stepAcc[N-1:0] : stepAcc[N-1:0];
    rem       = negA_q ? -stepAcc[2*N-1:N] : stepAcc[2*N-1:N];
    finalRes  = '0;
    case (op_q)
      3'b000:                 finalRes = prodFinal[N-1:0];
      3'b001, 3'b010, 3'b011: finalRes = prodFinal[2*N-1:N];
      3'b100, 3'b101: begin
        if (divZero_q)  finalRes = '1;
        else if (ovf_q) finalRes = MOST_NEG;
        else            finalRes = quo;
      end
      default: begin
        if (divZero_q)  finalRes = dvd_q;
        else if (ovf_q) finalRes = '0;
        else            finalRes = rem;
      end
    endcase
  end

  // Single FSM block; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      opA_q     <= '0;
      acc_q     <= '0;
      dvd_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            op_q      <= bus.op;
            negA_q    <= capNegA;
            negB_q    <= capNegB;
            dvd_q     <= bus.data1;
            divZero_q <= (bus.data2 == '0);
            ovf_q     <= (bus.op == 3'b100 || bus.op == 3'b110) &&
                         (bus.data1 == MOST_NEG) && (bus.data2 == '1);
            opA_q     <= bus.op[2] ? capAbsB : capAbsA;
            acc_q     <= bus.op[2] ? {{N{1'b0}}, capAbsA} : {{N{1'b0}}, capAbsB};
          end
        end
        CALC: begin
          if (bus.kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= stepAcc;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LAST_CNT) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= finalRes;
              cnt_q    <= '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed results, cycle-exact busy/result_valid
// timing, kill, ignored restart and mid-operation reset.
module tb_mdu_iter;
  localparam int N = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] lastResult;

  mdu_iter_if #(.DATA_WIDTH(N)) bus ();

  mdu_iter #(.DATA_WIDTH(N), .CNT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not terminate");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Walks cycles 1..N+2; optionally pulses a different request at cycle pulseAt.
  task automatic expectResult(input string tag, input logic [31:0] expected, input int pulseAt);
    for (int c = 1; c <= N + 1; c++) begin
      checkOutput($sformatf("%s busy c%0d", tag, c), {31'b0, bus.busy}, 32'd1);
      checkOutput($sformatf("%s valid c%0d", tag, c), {31'b0, bus.result_valid},
                  (c == N + 1) ? 32'd1 : 32'd0);
      if (c == N + 1) checkOutput($sformatf("%s result", tag), bus.result, expected);
      if (c == pulseAt) begin
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.data1 = 32'd3;
        bus.data2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput($sformatf("%s busy idle", tag), {31'b0, bus.busy}, 32'd0);
    checkOutput($sformatf("%s valid idle", tag), {31'b0, bus.result_valid}, 32'd0);
    checkOutput($sformatf("%s result hold", tag), bus.result, expected);
    lastResult = expected;
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(op, a, b);
    expectResult(tag, expected, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    lastResult = '0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.op     = '0;
    bus.data1  = '0;
    bus.data2  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("reset valid", {31'b0, bus.result_valid}, 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    runOp("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    runOp("MULH", OP_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    runOp("MULHSU", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("MULHU", OP_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runOp("REM -7%2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);

    // Kill at cycle 10 of a DIV, then restart in cycle 11.
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    checkOutput("kill busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("kill valid", {31'b0, bus.result_valid}, 32'd0);
    checkOutput("kill result kept", bus.result, lastResult);
    runOp("REMU after kill", OP_REMU, 32'd100, 32'd7, 32'd2);

    runOp("DIV by zero", OP_DIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    runOp("REMU by zero", OP_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);
    runOp("DIV overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runOp("REM overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // A start pulse mid-operation must neither recapture nor spawn a second result.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    expectResult("ignored start", 32'd14, 5);
    @(negedge clk);
    checkOutput("ignored start no 2nd valid", {31'b0, bus.result_valid}, 32'd0);
    checkOutput("ignored start no 2nd busy", {31'b0, bus.busy}, 32'd0);

    bus.start = 1'b1;
    bus.kill  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    checkOutput("kill blocks start", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);

    applyStimulus(OP_MUL, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("mid reset valid", {31'b0, bus.result_valid}, 32'd0);
    checkOutput("mid reset result", bus.result, 32'd0);
    runOp("MUL after reset", OP_MUL, 32'd5, 32'd6, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ALU operand-select stage. It consumes the selected operands data1/data2 when the decoder flags an M-extension instruction. It computes one result over a fixed multi-cycle latency and holds busy high so the hazard unit stalls the pipeline. The result is written back through the EX result mux.

Parameters:
DATA_WIDTH, 32, operand/result width (from my_pkg; must be even, >= 8)
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active high
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data1  input  DATA_WIDTH  operand A (rs1 path from operand select)
data2  input  DATA_WIDTH  operand B (rs2 path from operand select)
kill  input  1  pipeline flush; aborts any operation in flight
busy  output  1  high in CALC and DONE
result_valid  output  1  one-cycle pulse, high only in DONE
result  output  DATA_WIDTH  result; valid only while result_valid is high

Behaviour:
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on start=1 and kill=0.
  - CALC -> DONE when the counter reaches DATA_WIDTH-1.
  - DONE -> IDLE unconditionally.
- Reset (rst=1 at an edge): state=IDLE, counter=0, busy=0, result_valid=0, result=0, internal accumulators=0. Reset overrides kill and start.
- Capture at the start edge:
  - op, the operand sign flags, and the absolute values of the operands.
  - Signed treatment: data1 is signed for MULH, MULHSU, DIV, REM. data2 is signed for MULH, DIV, REM. MUL is sign-agnostic for the low half.
  - Negation uses two's complement; the most-negative value is treated as its unsigned magnitude.
- Latency:
  - start asserted in cycle 0 (IDLE) -> busy=1 in cycles 1..N+1, where N=DATA_WIDTH.
  - CALC occupies cycles 1..N, one iteration per cycle.
  - result_valid=1 in cycle N+1 only. Total is N+1 cycles for every op, including special cases.
- Multiply: shift-add, one multiplier bit per iteration, on a 2N-bit unsigned product.
  - Negate the product on the final edge when the sign flags differ.
  - MUL returns the low N bits; MULH, MULHSU and MULHU return the high N bits.
- Divide: restoring, one quotient bit per iteration, on unsigned magnitudes.
  - The quotient is negated when the operand signs differ (signed ops).
  - The remainder takes the sign of the dividend.
- Special cases, resolved on the final CALC edge:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> data1 as captured.
  - Signed overflow (data1 = most negative, data2 = -1): DIV -> most negative; REM -> 0.
- Result register: loaded only on the CALC->DONE edge. It holds its value in IDLE until the next completion; it is not cleared on new start.
- start in CALC or DONE: ignored; op and operands are not recaptured. Upstream must hold the instruction while busy=1.
- kill:
  - In CALC or DONE: next state IDLE, counter=0, result_valid=0 next cycle, result unchanged.
  - kill=1 with start=1 in IDLE: start is not accepted.
  - kill in the DONE cycle does not suppress the current result_valid=1 (already registered). It only forces IDLE, which is the next state anyway.
- Back-to-back: a new start is accepted no earlier than cycle N+2 (the first IDLE cycle).
- Outputs are driven purely from registers (no combinational path from inputs to outputs).

Test Plan:
- MUL: data1=7, data2=-3 (0xFFFFFFFD), start at cycle 0 -> result_valid only in cycle 33, result=0xFFFFFFEB; busy high in cycles 1..33.
- MULH/MULHSU/MULHU with data1=0x80000000, data2=0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV/REM with data1=-7, data2=2 -> -3 (0xFFFFFFFD) / -1 (0xFFFFFFFF); DIVU with 100 / 7 -> 14; REMU -> 2.
- Divide by zero, data1=0x1234, data2=0: DIV -> 0xFFFFFFFF, REMU -> 0x1234. Overflow 0x80000000/-1: DIV -> 0x80000000, REM -> 0. All still at latency 33.
- kill at cycle 10 of a DIV -> busy=0 from cycle 11, no result_valid, result retains its previous value. A new start in cycle 11 completes at cycle 44. A start pulsed during cycles 2..32 of an operation is ignored (no second result_valid).
- rst asserted mid-CALC -> next cycle busy=0, result_valid=0, result=0.
